// File: rtl/priority_resolver_fsm.sv
// Registered N-input priority resolver with ISR, EOI handling, rotation and INT/ACK handshake.
// Resolution is combinational; every output and all state update on the rising clock edge.
module priority_resolver_fsm #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] interrupt_request,
    input  logic [NUM_IRQ-1:0] interrupt_mask,
    input  logic               special_mask_mode,
    input  logic               special_fully_nest_config,
    input  logic               auto_eoi,
    input  logic               rotate_on_eoi,
    input  logic               int_ack,
    input  logic               eoi,
    input  logic               eoi_specific,
    input  logic [IDX_W-1:0]   eoi_level,
    input  logic               set_priority,
    output logic               int_out,
    output logic               vector_valid,
    output logic [IDX_W-1:0]   vector_index,
    output logic               spurious,
    output logic [NUM_IRQ-1:0] in_service_register,
    output logic [IDX_W-1:0]   priority_rotate
);
    typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACK} state_t;

    state_t             r_state, w_next;
    logic               r_int_out, r_vector_valid, r_spurious;
    logic [IDX_W-1:0]   r_vector_index, r_rotate;
    logic [NUM_IRQ-1:0] r_isr;

    // Rank 0 is the highest priority: the level just above the rotation pointer.
    function automatic logic [IDX_W-1:0] rank_of(input logic [IDX_W-1:0] lvl,
                                                 input logic [IDX_W-1:0] rot);
        return IDX_W'(lvl - rot - IDX_W'(1));
    endfunction

    // Returns {found, level} of the highest-priority set bit of vec.
    function automatic logic [IDX_W:0] find_hp(input logic [NUM_IRQ-1:0] vec,
                                               input logic [IDX_W-1:0]   rot);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] lvl;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            lvl = IDX_W'(rot + IDX_W'(1) + IDX_W'(k));
            if (vec[lvl]) begin
                found = 1'b1;
                idx   = lvl;
            end
        end
        return {found, idx};
    endfunction

    logic [NUM_IRQ-1:0] w_eligible, w_isr_block, w_qual;
    logic [IDX_W:0]     w_blk, w_cand, w_ns;
    logic [IDX_W-1:0]   w_blk_rank;
    logic               w_cand_vld, w_ack_take;

    assign w_eligible  = interrupt_request & ~interrupt_mask;
    assign w_isr_block = special_mask_mode ? (r_isr & ~interrupt_mask) : r_isr;
    assign w_blk       = find_hp(w_isr_block, r_rotate);
    assign w_blk_rank  = rank_of(w_blk[IDX_W-1:0], r_rotate);

    always_comb begin
        w_qual = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_qual[i] = !w_blk[IDX_W]
                     || (rank_of(IDX_W'(i), r_rotate) < w_blk_rank)
                     || (special_fully_nest_config && rank_of(IDX_W'(i), r_rotate) == w_blk_rank);
        end
    end

    assign w_cand     = find_hp(w_eligible & w_qual, r_rotate);
    assign w_cand_vld = w_cand[IDX_W];
    assign w_ack_take = (r_state == S_PEND) && int_ack;
    // Non-specific EOI looks at the raw ISR, mask does not matter here.
    assign w_ns       = find_hp(r_isr, r_rotate);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_cand_vld) w_next = S_PEND;
            S_PEND:  if (int_ack)    w_next = S_ACK;
            S_ACK:                   w_next = S_IDLE;
            default:                 w_next = S_IDLE;
        endcase
    end

    logic [NUM_IRQ-1:0] w_clr, w_set, w_isr_next;
    logic [IDX_W-1:0]   w_rot_next;

    always_comb begin
        w_clr      = '0;
        w_set      = '0;
        w_rot_next = r_rotate;
        if (eoi && w_ns[IDX_W]) begin
            w_clr[w_ns[IDX_W-1:0]] = 1'b1;
            if (rotate_on_eoi) w_rot_next = w_ns[IDX_W-1:0];
        end
        if (eoi_specific) w_clr[eoi_level] = 1'b1;
        if (w_ack_take && w_cand_vld) begin
            if (!auto_eoi)          w_set[w_cand[IDX_W-1:0]] = 1'b1;
            else if (rotate_on_eoi) w_rot_next = w_cand[IDX_W-1:0];
        end
        if (set_priority) w_rot_next = eoi_level;
        w_isr_next = (r_isr & ~w_clr) | w_set;
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_int_out      <= 1'b0;
            r_vector_valid <= 1'b0;
            r_vector_index <= '0;
            r_spurious     <= 1'b0;
            r_isr          <= '0;
            r_rotate       <= '1;
        end else begin
            r_int_out      <= (w_next == S_PEND);
            r_vector_valid <= w_ack_take;
            r_spurious     <= w_ack_take && !w_cand_vld;
            if (w_ack_take) r_vector_index <= w_cand_vld ? w_cand[IDX_W-1:0] : '1;
            r_isr          <= w_isr_next;
            r_rotate       <= w_rot_next;
        end
    end

    assign int_out             = r_int_out;
    assign vector_valid        = r_vector_valid;
    assign vector_index        = r_vector_index;
    assign spurious            = r_spurious;
    assign in_service_register = r_isr;
    assign priority_rotate     = r_rotate;
endmodule

// File: tb/tb_priority_resolver_fsm.sv
// Scoreboard bench for priority_resolver_fsm: N=8 main instance plus an N=16 reset check.
module tb_priority_resolver_fsm;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] irq = '0, mask = '0;
    logic       smm = 1'b0, sfnm = 1'b0, aeoi = 1'b0, roe = 1'b0;
    logic       ack = 1'b0, eoi = 1'b0, eoi_sp = 1'b0, setp = 1'b0;
    logic [2:0] lvl = '0;
    logic       int_out, vv, sp;
    logic [2:0] vi, rot;
    logic [7:0] isr;

    logic        rst16 = 1'b1, ack16 = 1'b0;
    logic [15:0] irq16 = '0;
    logic        int16, vv16, sp16;
    logic [3:0]  vi16, rot16;
    logic [15:0] isr16;

    always #5 clock = ~clock;

    priority_resolver_fsm #(.NUM_IRQ(8)) dut (
        .clock(clock), .reset(reset), .interrupt_request(irq), .interrupt_mask(mask),
        .special_mask_mode(smm), .special_fully_nest_config(sfnm), .auto_eoi(aeoi),
        .rotate_on_eoi(roe), .int_ack(ack), .eoi(eoi), .eoi_specific(eoi_sp),
        .eoi_level(lvl), .set_priority(setp), .int_out(int_out), .vector_valid(vv),
        .vector_index(vi), .spurious(sp), .in_service_register(isr), .priority_rotate(rot));

    priority_resolver_fsm #(.NUM_IRQ(16)) dut16 (
        .clock(clock), .reset(rst16), .interrupt_request(irq16), .interrupt_mask(16'h0),
        .special_mask_mode(1'b0), .special_fully_nest_config(1'b0), .auto_eoi(1'b0),
        .rotate_on_eoi(1'b0), .int_ack(ack16), .eoi(1'b0), .eoi_specific(1'b0),
        .eoi_level(4'h0), .set_priority(1'b0), .int_out(int16), .vector_valid(vv16),
        .vector_index(vi16), .spurious(sp16), .in_service_register(isr16),
        .priority_rotate(rot16));

    typedef struct packed { logic [2:0] idx; logic spur; } exp_t;
    exp_t sb[$];
    int   n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic wait_int();
        for (int i = 0; i < 10 && int_out !== 1'b1; i++) tick();
        chk("int_up", int_out, 1);
    endtask

    task automatic do_ack(input logic [2:0] idx, input logic spur);
        sb.push_back('{idx: idx, spur: spur});
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (vv === 1'b1) begin
            if (sb.size() == 0) chk("sb_unexpected_vv", 1, 0);
            else begin
                e = sb.pop_front();
                chk("vec_idx", vi, e.idx);
                chk("vec_spur", sp, e.spur);
            end
        end
    end

    initial begin
        tick(); tick();
        reset = 1'b0; rst16 = 1'b0;
        chk("rst_int", int_out, 0); chk("rst_vv", vv, 0); chk("rst_vi", vi, 0);
        chk("rst_sp", sp, 0); chk("rst_isr", isr, 0); chk("rst_rot", rot, 7);
        chk("rst16_rot", rot16, 15); chk("rst16_isr", isr16, 0);

        // fixed order
        irq = 8'hFF; tick(); chk("fixed_int", int_out, 1);
        do_ack(0, 0); chk("fixed_isr", isr, 8'h01);
        irq = 8'hFE; eoi = 1; tick(); eoi = 0; chk("fixed_eoi", isr, 0);
        wait_int(); do_ack(1, 0); chk("fixed_isr2", isr, 8'h02);
        irq = 0; eoi = 1; tick(); eoi = 0; chk("fixed_clr", isr, 0);

        // nesting block, then SFNM
        irq = 8'h04; wait_int(); do_ack(2, 0);
        irq = 8'h24; tick(); tick(); tick();
        chk("nest_block", int_out, 0); chk("nest_isr", isr, 8'h04);
        sfnm = 1; wait_int(); do_ack(2, 0); chk("sfnm_isr", isr, 8'h04);
        sfnm = 0; irq = 0; eoi_sp = 1; lvl = 2; tick(); eoi_sp = 0;
        chk("sp_eoi", isr, 0);

        // special mask mode, then eoi + eoi_specific together
        irq = 8'h01; wait_int(); do_ack(0, 0);
        irq = 8'h08; mask = 8'h01; smm = 1; wait_int(); do_ack(3, 0);
        chk("smm_isr", isr, 8'h09);
        smm = 0; mask = 0; irq = 0; eoi = 1; eoi_sp = 1; lvl = 3; tick();
        eoi = 0; eoi_sp = 0; chk("both_eoi", isr, 0);

        // rotation
        roe = 1; irq = 8'h08; wait_int(); do_ack(3, 0);
        irq = 0; eoi = 1; tick(); eoi = 0; chk("rot_eoi", rot, 3);
        irq = 8'h1C; wait_int(); do_ack(4, 0); chk("rot_isr", isr, 8'h10);
        irq = 0; eoi_sp = 1; lvl = 4; tick(); eoi_sp = 0;
        chk("sp_norot", rot, 3); chk("sp_norot_isr", isr, 0);
        setp = 1; lvl = 6; tick(); setp = 0; chk("setp", rot, 6);
        irq = 8'h81; wait_int(); do_ack(7, 0);
        irq = 0; eoi = 1; setp = 1; lvl = 5; tick(); eoi = 0; setp = 0;
        chk("setp_prec", rot, 5); chk("setp_prec_isr", isr, 0);

        // auto-EOI with rotation
        aeoi = 1; irq = 8'h04; wait_int(); do_ack(2, 0);
        chk("aeoi_isr", isr, 0); chk("aeoi_rot", rot, 2);
        aeoi = 0; roe = 0; irq = 0; tick();

        // spurious
        irq = 8'h20; wait_int(); irq = 0; tick(); chk("spur_pend", int_out, 1);
        do_ack(7, 1); chk("spur_isr", isr, 0); chk("spur_intlo", int_out, 0);
        tick(); tick();

        // reset mid-handshake
        irq = 8'h10; wait_int(); do_ack(4, 0);
        irq = 8'h08; wait_int(); chk("mid_isr", isr, 8'h10);
        reset = 1; ack = 1; tick(); reset = 0; ack = 0; irq = 0;
        chk("mr_int", int_out, 0); chk("mr_vv", vv, 0); chk("mr_vi", vi, 0);
        chk("mr_sp", sp, 0); chk("mr_isr", isr, 0); chk("mr_rot", rot, 7);
        tick(); chk("mr_ack_drop", vv, 0);

        // N=16
        irq16 = 16'h8000;
        for (int i = 0; i < 10 && int16 !== 1'b1; i++) tick();
        chk("n16_int", int16, 1);
        rst16 = 1; ack16 = 1; tick(); rst16 = 0; ack16 = 0; irq16 = 0;
        chk("n16_rot", rot16, 15); chk("n16_int_lo", int16, 0);
        chk("n16_vv", vv16, 0); chk("n16_isr", isr16, 0);
        tick();

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
